// File: rtl/bus_sel_seq_if.sv
// Select-code bus between the round-robin sequencer and the downstream 3-way mux.
// The sequencer takes master; a consumer or bench takes slave.
interface bus_sel_seq_if;
   logic [2:0] req;
   logic [1:0] bus;
   logic       bus_vld;
   logic [2:0] gnt;
   logic       done;

   modport master (input req, output bus, bus_vld, gnt, done);
   modport slave  (output req, input bus, bus_vld, gnt, done);
endinterface

// File: rtl/bus_sel_seq.sv
// Round-robin sequencer driving the 2-bit select code for the in1/in2/reset-path mux.
// Each grant is held for at most DWELL cycles, and GAP idle cycles separate grants.
module bus_sel_seq #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned GAP   = 1
) (
   input  logic          clk,
   input  logic          reset,
   bus_sel_seq_if.master bif
);

   typedef enum logic [1:0] {IDLE, GRANT, GAPW} state_t;

   localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);
   localparam logic [1:0] GAP_LOAD   = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [1:0] gap_cnt, gap_nxt;
   logic [1:0] last, last_nxt;
   logic [1:0] bus_nxt;
   logic       vld_nxt;
   logic [2:0] gnt_nxt;
   logic [1:0] win, cand;
   logic       win_ok;
   logic       start;
   logic       grant_end;
   logic       done_c;

   // Search begins one past the last granted index, wrapping 2 -> 0.
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      cand   = '0;
      for (int unsigned k = 1; k <= 3; k++) begin
         cand = 2'((32'(last) + k) % 32'd3);
         if (!win_ok && bif.req[cand]) begin
            win_ok = 1'b1;
            win    = cand;
         end
      end
   end

   assign grant_end = (state == GRANT) && ((cnt == '0) || ((bif.req & bif.gnt) == '0));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gap_nxt   = gap_cnt;
      last_nxt  = last;
      bus_nxt   = bif.bus;
      vld_nxt   = bif.bus_vld;
      gnt_nxt   = bif.gnt;
      done_c    = 1'b0;
      start     = 1'b0;

      unique case (state)
         IDLE: begin
            if (win_ok) start = 1'b1;
         end
         GRANT: begin
            if (cnt != '0) cnt_nxt = cnt - 4'd1;
            if (grant_end) begin
               done_c  = 1'b1;
               bus_nxt = '0;
               vld_nxt = 1'b0;
               gnt_nxt = '0;
               if (GAP > 0) begin
                  state_nxt = GAPW;
                  gap_nxt   = GAP_LOAD;
               end else if (win_ok) begin
                  start = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         GAPW: begin
            if (gap_cnt != '0) begin
               gap_nxt = gap_cnt - 2'd1;
            end else if (win_ok) begin
               start = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A new grant overrides whatever the end-of-grant path cleared above.
      if (start) begin
         state_nxt = GRANT;
         bus_nxt   = win;
         gnt_nxt   = 3'b001 << win;
         vld_nxt   = 1'b1;
         cnt_nxt   = DWELL_LOAD;
         last_nxt  = win;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         gap_cnt     <= '0;
         last        <= 2'd2;
         bif.bus     <= '0;
         bif.bus_vld <= 1'b0;
         bif.gnt     <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         gap_cnt     <= gap_nxt;
         last        <= last_nxt;
         bif.bus     <= bus_nxt;
         bif.bus_vld <= vld_nxt;
         bif.gnt     <= gnt_nxt;
      end
   end

   // An aborted grant must not report completion.
   assign bif.done = done_c & ~reset;

endmodule

// File: tb/tb_bus_sel_seq.sv
// Scoreboard bench: two sequencers (defaults, and DWELL=2/GAP=0) share the stimulus
// and are compared against a grant-ownership model of the arbitration rules.
module tb_bus_sel_seq;

   typedef struct {
      int owner;     // granted index, -1 when no grant is held
      int held;      // granted cycles so far, counting the current one
      int gap_left;  // idle cycles still to serve, counting the current one
      int last;
   } m_t;

   typedef struct {
      logic [1:0] bus;
      logic       vld;
      logic [2:0] gnt;
      logic       done;
   } exp_t;

   localparam int D0 = 4, G0 = 1;
   localparam int D1 = 2, G1 = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req_drv;
   int         n_checks = 0;
   int         n_fail   = 0;
   exp_t       q0[$];
   exp_t       q1[$];

   bus_sel_seq_if if0 ();
   bus_sel_seq_if if1 ();
   assign if0.req = req_drv;
   assign if1.req = req_drv;

   bus_sel_seq #(.DWELL(D0), .GAP(G0)) dut0 (.clk(clk), .reset(rst), .bif(if0));
   bus_sel_seq #(.DWELL(D1), .GAP(G1)) dut1 (.clk(clk), .reset(rst), .bif(if1));

   always #5 clk = ~clk;

   function automatic m_t step(m_t m, logic [2:0] r, logic rs, int dwell, int gap);
      m_t n = m;
      bit arb = 0;
      if (rs) begin
         n.owner = -1; n.held = 0; n.gap_left = 0; n.last = 2;
         return n;
      end
      if (m.owner >= 0) begin
         if (m.held >= dwell || !r[m.owner]) begin
            n.owner = -1;
            if (gap > 0) n.gap_left = gap;
            else arb = 1;
         end else begin
            n.held = m.held + 1;
         end
      end else if (m.gap_left > 1) begin
         n.gap_left = m.gap_left - 1;
      end else begin
         n.gap_left = 0;
         arb = 1;
      end
      if (arb) begin
         for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m.last + k) % 3;
            if (r[i]) begin
               n.owner = i; n.held = 1; n.last = i;
               break;
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t outs(m_t m, logic [2:0] r, logic rs, int dwell);
      exp_t e;
      e.bus = 2'd0; e.vld = 1'b0; e.gnt = 3'd0; e.done = 1'b0;
      if (m.owner >= 0) begin
         e.bus  = 2'(m.owner);
         e.vld  = 1'b1;
         e.gnt  = 3'(1 << m.owner);
         e.done = !rs && (m.held == dwell || !r[m.owner]);
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic [1:0] bus,
                            input logic vld, input logic [2:0] gnt, input logic done,
                            input int dwell, inout int run, inout bit pdone, inout bit pvld);
      logic [2:0] gnt_from_bus;
      chk({tag, ".bus"}, int'(bus), int'(e.bus));
      chk({tag, ".bus_vld"}, int'(vld), int'(e.vld));
      chk({tag, ".gnt"}, int'(gnt), int'(e.gnt));
      chk({tag, ".done"}, int'(done), int'(e.done));
      chk({tag, ".bus_legal"}, int'(bus == 2'b11), 0);
      gnt_from_bus = vld ? (3'b001 << bus) : 3'b000;
      chk({tag, ".gnt_consistent"}, int'(gnt), int'(gnt_from_bus));
      if (vld) run = (pdone || !pvld) ? 1 : run + 1;
      else run = 0;
      chk({tag, ".dwell_max"}, int'(run > dwell), 0);
      pdone = done;
      pvld  = vld;
   endtask

   // Monitor: pops one expected response per presented cycle for each sequencer.
   initial begin
      int  run0 = 0, run1 = 0;
      bit  pd0 = 0, pv0 = 0, pd1 = 0, pv1 = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check_dut("d0", e, if0.bus, if0.bus_vld, if0.gnt, if0.done, D0, run0, pd0, pv0);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check_dut("d1", e, if1.bus, if1.bus_vld, if1.gnt, if1.done, D1, run1, pd1, pv1);
         end
      end
   end

   // Driver: applies inputs after the edge, queues the expected response, then
   // advances the models through the next edge.
   m_t m0, m1;
   bit known = 0;

   task automatic drive(input logic [2:0] r, input logic rs);
      req_drv = r;
      rst     = rs;
      if (known) begin
         q0.push_back(outs(m0, r, rs, D0));
         q1.push_back(outs(m1, r, rs, D1));
      end
      @(posedge clk);
      #1;
      m0 = step(m0, r, rs, D0, G0);
      m1 = step(m1, r, rs, D1, G1);
      if (rs) known = 1;
   endtask

   task automatic hold(input logic [2:0] r, input int n);
      for (int i = 0; i < n; i++) drive(r, 1'b0);
   endtask

   initial begin
      logic [2:0] r;
      logic       rs;
      req_drv = '0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive(3'b000, 1'b1);
      hold(3'b001, 12);
      hold(3'b000, 3);
      hold(3'b111, 20);
      hold(3'b000, 3);
      hold(3'b010, 2);
      hold(3'b000, 4);
      hold(3'b011, 10);
      hold(3'b000, 3);
      // idle, grant1, grant2, then reset during the third granted cycle
      hold(3'b001, 3);
      drive(3'b001, 1'b1);
      hold(3'b111, 6);
      r = 3'b000;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0) r = 3'($urandom_range(7));
         rs = ($urandom_range(199) == 0);
         drive(r, rs);
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_sel_seq.md
BUS_SEL_SEQ -- requirements
Module: bus_sel_seq

Purpose: upstream stage that generates the 2-bit `bus` select code for the downstream 3-way select mux. Codes: 00=in1, 01=in2, 10=reset path. The code 11 is illegal and is never driven.

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the maximum cycles one grant is held (legal range 1..15).
REQ-002 The block SHALL have parameter GAP, default 1, giving the idle cycles inserted between grants (legal range 0..3).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  requests: bit0=in1, bit1=in2, bit2=reset path; level-sensitive, held until granted.
REQ-006 bus  output  2  select code to downstream mux; registered.
REQ-007 bus_vld  output  1  high while `bus` carries a granted code; registered.
REQ-008 gnt  output  3  one-hot grant matching `bus` when `bus_vld` is high, else 000; registered.
REQ-009 done  output  1  one-cycle pulse in the last cycle of each grant.

Function
REQ-010 The block SHALL implement states IDLE, GRANT and GAPW.
REQ-011 IDLE: if `req`!=0, the block SHALL enter GRANT on the next edge, with the winner chosen by round-robin; otherwise it SHALL remain in IDLE.
REQ-012 Round-robin: the search SHALL start at the index after the last granted index, wrapping 2->0; after reset the last granted index SHALL be 2, so index 0 has priority.
REQ-013 On entry to GRANT the block SHALL register `bus`=winner index (00/01/10), `gnt`=one-hot winner and `bus_vld`=1, and SHALL load the dwell counter with DWELL-1.
REQ-014 Latency: a request seen in IDLE SHALL produce `bus_vld`=1 exactly one cycle later.
REQ-015 In GRANT the dwell counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-016 A grant SHALL end when the counter is 0 or when the granted `req` bit is low; `done` SHALL be 1 in that cycle.
REQ-017 If a grant ends and GAP>0, the block SHALL enter GAPW with `bus_vld`=0, `gnt`=000 and `bus`=00, and SHALL stay there for exactly GAP cycles.
REQ-018 If a grant ends and GAP=0, the block SHALL arbitrate in the same cycle and go directly to GRANT (back-to-back grants) if any request is pending, and to IDLE otherwise.
REQ-019 When GAPW expires, the block SHALL behave as IDLE: arbitrate if `req`!=0, otherwise go to IDLE.
REQ-020 The round-robin pointer SHALL update only when a new grant is issued.
REQ-021 `bus` SHALL never equal 2'b11 in any state, including immediately after reset.
REQ-022 A sole requester SHALL be re-granted after GAP idle cycles, so continuous requesters are not starved.
REQ-023 While `bus_vld`=0, `bus` SHALL be 00 and `gnt` SHALL be 000.
REQ-024 The counter SHALL be 4 bits wide; a DWELL-1 load SHALL never overflow it.

Reset
REQ-025 While `reset`=1 at a clock edge, the block SHALL force state=IDLE, `bus`=00, `bus_vld`=0, `gnt`=000, `done`=0, counter=0 and last-granted index=2.
REQ-026 Reset asserted mid-grant or mid-gap SHALL take effect at the next edge, and `done` SHALL not pulse for the aborted grant.
REQ-027 After `reset` deasserts, the first grant SHALL follow REQ-011 and REQ-014.

Verification
REQ-028 Defaults, req=001 held 10 cycles: `bus_vld` SHALL rise 1 cycle after req, `bus`=00 for 4 cycles with `done` on the 4th cycle, then 1 gap cycle, then re-grant.
REQ-029 req=111 held, defaults: `bus` SHALL follow the sequence 00,01,10,00 with 4-cycle grants separated by single `bus_vld`=0 cycles.
REQ-030 req=010 dropped after 2 granted cycles: the grant SHALL end with `done` in the 2nd granted cycle, then GAPW, then IDLE.
REQ-031 GAP=0, req=011 held: `bus` SHALL change 00->01 with no `bus_vld`=0 cycle between grants.
REQ-032 Reset pulsed during the 3rd granted cycle: the next cycle SHALL show `bus`=00, `bus_vld`=0, `gnt`=000, `done`=0, and the first post-reset grant SHALL go to index 0.
REQ-033 Random `req` for 10k cycles: an assertion SHALL check that `bus`!=11, that `gnt` is one-hot or zero and consistent with `bus`/`bus_vld`, and that no grant exceeds DWELL cycles.
